secp256k1_mul_mod: RTL and testbench

Bit-serial modular multiplier computing r = (a · b) mod p for the secp256k1 prime p = 2^256 − 2^32 − 977. It is the product stage directly upstream of the modular subtractor in the point add/double datapath. Its products, such as λ², X·Z² and Y·Z³, feed the subtractor's a/b operands. It uses the same start/done pulse handshake as the other field-arithmetic units, so the sequencer can chain the two units directly.

---
 rtl/secp256k1_mul_mod.sv | 124 ++++++++++++
 tb/tb_secp256k1_mul_mod.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/secp256k1_mul_mod.sv
// Bit-serial MSB-first modular multiplier over the secp256k1 field prime.
// One double-and-add step per cycle; the accumulator stays fully reduced below P.
module secp256k1_mul_mod (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] a,
    input  logic [255:0] b,
    output logic [255:0] result,
    output logic         done,
    output logic         busy
);

    localparam int unsigned W  = 256;
    localparam int unsigned CW = 8;
    localparam logic [W-1:0] P =
        256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [W:0]    P_X      = {1'b0, P};
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOOP = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e        state_q,  state_d;
    logic [W-1:0]  acc_q,    acc_d;
    logic [W-1:0]  a_r_q,    a_r_d;
    logic [W-1:0]  b_r_q,    b_r_d;
    logic [W-1:0]  result_q, result_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic          done_q,   done_d;
    logic          busy_q,   busy_d;

    logic [W-1:0]  a_in_red;
    logic [W:0]    dbl;
    logic [W-1:0]  dbl_red;
    logic [W:0]    sum;
    logic [W-1:0]  step_res;

    // One iteration: acc <- 2*acc (+ a_r) mod P, each with a single conditional subtract
    always_comb begin
        a_in_red = (a >= P) ? W'(a - P) : a;
        dbl      = {acc_q, 1'b0};
        dbl_red  = (dbl >= P_X) ? W'(dbl - P_X) : W'(dbl);
        sum      = {1'b0, dbl_red} + {1'b0, a_r_q};
        step_res = dbl_red;
        if (b_r_q[cnt_q]) begin
            step_res = (sum >= P_X) ? W'(sum - P_X) : W'(sum);
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        a_r_d    = a_r_q;
        b_r_d    = b_r_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        busy_d   = busy_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_r_d   = a_in_red;
                    b_r_d   = b;
                    acc_d   = '0;
                    cnt_d   = CNT_LAST;
                    busy_d  = 1'b1;
                    state_d = S_LOOP;
                end
            end
            S_LOOP: begin
                acc_d = step_res;
                if (cnt_q == '0) begin
                    result_d = step_res;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                // busy stays high through the done cycle
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            a_r_q    <= '0;
            b_r_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            a_r_q    <= a_r_d;
            b_r_q    <= b_r_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_secp256k1_mul_mod.sv
// Directed bench for secp256k1_mul_mod: latency, handshake, reduction corner cases
// and asynchronous reset mid-operation.
module tb_secp256k1_mul_mod;

    localparam logic [255:0] P =
        256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] result;
    logic         done;
    logic         busy;

    int n_checks;
    int n_errors;

    secp256k1_mul_mod dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        int ndone;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (result !== '0 || done !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_hold: result=%h done=%b busy=%b, expected all zero", result, done, busy);
        end
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        n_checks++;
        if (result !== '0 || busy !== 1'b0 || ndone != 0) begin
            n_errors++;
            $display("FAIL reset_idle: result=%h busy=%b dones=%0d, expected 0/0/0", result, busy, ndone);
        end
    endtask

    // Issue one operation; optionally pulse start again at cycle dup_at (0 = never).
    task automatic run_op(input logic [255:0] op_a, input logic [255:0] op_b,
                          input logic [255:0] exp, input string name, input int dup_at);
        int           lat;
        int           ndone;
        logic [255:0] res;
        @(posedge clk);
        #1;
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = {8{$urandom}};
        b     = {8{$urandom}};
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_busy_start: busy=%b done=%b, expected 1/0", name, busy, done);
        end
        lat   = 0;
        ndone = 0;
        res   = '0;
        for (int k = 1; k <= 600; k++) begin
            if (dup_at != 0 && k == dup_at) begin
                start = 1'b1;
                a     = 256'd9;
                b     = 256'd9;
            end
            if (dup_at != 0 && k == dup_at + 1) start = 1'b0;
            @(posedge clk);
            #1;
            if (k == 256) begin
                n_checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s_busy_mid: busy=%b done=%b, expected 1/0", name, busy, done);
                end
            end
            if (done === 1'b1) begin
                ndone++;
                if (lat == 0) begin
                    lat = k;
                    res = result;
                    n_checks++;
                    if (busy !== 1'b1) begin
                        n_errors++;
                        $display("FAIL %s_busy_done: busy=%b, expected 1", name, busy);
                    end
                end
            end
            if (lat != 0 && k == lat + 1) begin
                n_checks++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s_pulse_end: done=%b busy=%b, expected 0/0", name, done, busy);
                end
            end
        end
        n_checks++;
        if (lat != 257) begin
            n_errors++;
            $display("FAIL %s_latency: got %0d cycles, expected 257 (0 = timeout)", name, lat);
        end
        n_checks++;
        if (res !== exp) begin
            n_errors++;
            $display("FAIL %s_result: got %h expected %h", name, res, exp);
        end
        n_checks++;
        if (ndone != 1 || result !== exp) begin
            n_errors++;
            $display("FAIL %s_single_done_hold: dones=%0d held=%h, expected 1 and %h", name, ndone, result, exp);
        end
    endtask

    task automatic test_identity_wrap();
        run_op(256'd1, 256'd1, 256'd1, "one_one", 0);
        run_op(P - 256'd1, P - 256'd1, 256'd1, "pm1_sq", 0);
        run_op(256'd2, P - 256'd1, P - 256'd2, "two_pm1", 0);
    endtask

    task automatic test_overflow();
        logic [255:0] two128;
        two128 = 256'd1 << 128;
        run_op(two128, two128, 256'h1000003D1, "pow256", 0);
    endtask

    task automatic test_unreduced();
        run_op(P, 256'd5, 256'd0, "a_eq_p", 0);
        run_op(P + 256'd3, 256'd2, 256'd6, "a_p_plus3", 0);
        run_op(256'd7, {256{1'b1}}, 256'h700001AB0, "b_all_ones", 0);
    endtask

    task automatic test_start_while_busy();
        run_op(256'd5, 256'd6, 256'd30, "dup_start", 100);
    endtask

    task automatic test_back_to_back();
        int           d1;
        int           d2;
        logic [255:0] r1;
        logic [255:0] r2;
        logic [255:0] two128;
        two128 = 256'd1 << 128;
        d1 = 0;
        d2 = 0;
        r1 = '0;
        r2 = '0;
        @(posedge clk);
        #1;
        a     = two128;
        b     = two128;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 256'd11;
        b = 256'd13;
        for (int k = 1; k <= 700; k++) begin
            @(posedge clk);
            #1;
            if (k == 258) begin
                start = 1'b0;
                a     = 256'd99;
                b     = 256'd99;
                n_checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    n_errors++;
                    $display("FAIL b2b_recapture: busy=%b done=%b, expected 1/0", busy, done);
                end
            end
            if (done === 1'b1) begin
                if (d1 == 0) begin
                    d1 = k;
                    r1 = result;
                end else if (d2 == 0) begin
                    d2 = k;
                    r2 = result;
                end
            end
        end
        n_checks++;
        if (d1 != 257 || d2 != 515) begin
            n_errors++;
            $display("FAIL b2b_timing: dones at %0d and %0d, expected 257 and 515", d1, d2);
        end
        n_checks++;
        if (r1 !== 256'h1000003D1) begin
            n_errors++;
            $display("FAIL b2b_result0: got %h expected %h", r1, 256'h1000003D1);
        end
        n_checks++;
        if (r2 !== 256'd143) begin
            n_errors++;
            $display("FAIL b2b_result1: got %h expected %h", r2, 256'd143);
        end
    endtask

    task automatic test_mid_reset();
        int ndone;
        ndone = 0;
        @(posedge clk);
        #1;
        a     = P - 256'd1;
        b     = P - 256'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 128; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (result !== '0 || done !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_async: result=%h done=%b busy=%b, expected all zero", result, done, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        n_checks++;
        if (ndone != 0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_no_done: dones=%0d busy=%b, expected 0/0", ndone, busy);
        end
        run_op(256'd3, 256'd4, 256'd12, "after_rst", 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        test_reset();
        test_identity_wrap();
        test_overflow();
        test_unreduced();
        test_start_while_busy();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
